// File: rtl/sdram_pkg.sv
// Shared widths, FSM encoding and address helpers for the SDRAM request controller.
package sdram_pkg;

    localparam int BA_W   = 3;
    localparam int ROW_W  = 15;
    localparam int COL_W  = 10;
    localparam int DATA_W = 8;
    localparam int ADDR_W = BA_W + ROW_W + COL_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_ACTIVATE  = 3'd2,
        ST_ACCESS    = 3'd3,
        ST_RDWAIT    = 3'd4
    } ctrl_state_t;

    typedef struct packed {
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } mem_addr_t;

    // Host address is {bank, row, col} with the bank in the MSBs.
    function automatic mem_addr_t split_addr(input logic [ADDR_W-1:0] addr);
        return mem_addr_t'(addr);
    endfunction

endpackage

// File: rtl/sdram_if.sv
// Host request/response port and memory pin bundle for the SDRAM controller.
interface sdram_host_if #(
    parameter int BA_W   = sdram_pkg::BA_W,
    parameter int ROW_W  = sdram_pkg::ROW_W,
    parameter int COL_W  = sdram_pkg::COL_W,
    parameter int DATA_W = sdram_pkg::DATA_W
);
    import sdram_pkg::*;

    logic                        req_valid;
    logic                        req_ready;
    logic                        req_we;
    logic [BA_W+ROW_W+COL_W-1:0] req_addr;
    logic [DATA_W-1:0]           req_wdata;
    logic                        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

interface sdram_mem_if #(
    parameter int BA_W   = sdram_pkg::BA_W,
    parameter int ROW_W  = sdram_pkg::ROW_W,
    parameter int COL_W  = sdram_pkg::COL_W,
    parameter int DATA_W = sdram_pkg::DATA_W
);
    import sdram_pkg::*;

    logic              mem_en;
    logic [BA_W-1:0]   mem_ba;
    logic [ROW_W-1:0]  mem_row;
    logic [COL_W-1:0]  mem_col;
    logic              mem_we_n;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en, mem_ba, mem_row, mem_col, mem_we_n, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_ba, mem_row, mem_col, mem_we_n, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sdram_row_table.sv
// Open-row tracker: one {open, row} entry per bank, looked up on request accept.
module sdram_row_table #(
    parameter int BA_W  = sdram_pkg::BA_W,
    parameter int ROW_W = sdram_pkg::ROW_W
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic [BA_W-1:0]  lk_ba_i,
    input  logic [ROW_W-1:0] lk_row_i,
    output logic             lk_hit_o,
    output logic             lk_open_o,
    input  logic             upd_en_i,
    input  logic [BA_W-1:0]  upd_ba_i,
    input  logic [ROW_W-1:0] upd_row_i
);
    import sdram_pkg::*;

    localparam int NBANK = 1 << BA_W;

    logic [NBANK-1:0] open_q;
    logic [NBANK-1:0] open_d;
    logic [ROW_W-1:0] row_q [NBANK];
    logic [ROW_W-1:0] row_d [NBANK];

    // An activate marks its bank open with the newly activated row.
    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        if (upd_en_i) begin
            open_d[upd_ba_i] = 1'b1;
            row_d[upd_ba_i]  = upd_row_i;
        end
    end

    // Table state; reset closes every bank.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            open_q <= '0;
            for (int i = 0; i < NBANK; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
        end
    end

    assign lk_open_o = open_q[lk_ba_i];
    assign lk_hit_o  = open_q[lk_ba_i] && (row_q[lk_ba_i] == lk_row_i);

endmodule

// File: rtl/sdram_ctrl.sv
// Single-outstanding SDRAM request controller with open-page row tracking.
module sdram_ctrl #(
    parameter int BA_W   = sdram_pkg::BA_W,
    parameter int ROW_W  = sdram_pkg::ROW_W,
    parameter int COL_W  = sdram_pkg::COL_W,
    parameter int DATA_W = sdram_pkg::DATA_W,
    parameter int T_RP   = 2,
    parameter int T_RCD  = 2,
    parameter int RD_LAT = 2
) (
    input logic         ck,
    input logic         rst_n,
    sdram_host_if.slave host,
    sdram_mem_if.master mem
);
    import sdram_pkg::*;

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_PRECHARGE = ST_PRECHARGE;
    localparam logic [2:0] S_ACTIVATE  = ST_ACTIVATE;
    localparam logic [2:0] S_ACCESS    = ST_ACCESS;
    localparam logic [2:0] S_RDWAIT    = ST_RDWAIT;

    localparam int T_MAX0 = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int T_MAX  = (T_MAX0 > RD_LAT) ? T_MAX0 : RD_LAT;
    localparam int CNT_W  = $clog2(T_MAX) + 1;

    // Counter reload values: a phase of T cycles ends when the counter reads zero.
    localparam logic [CNT_W-1:0] CNT_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] CNT_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] CNT_RD  = CNT_W'(RD_LAT - 1);

    logic [2:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              rdy_q,       rdy_d;
    logic              we_q,        we_d;
    logic [BA_W-1:0]   ba_q,        ba_d;
    logic [ROW_W-1:0]  row_q,       row_d;
    logic [COL_W-1:0]  col_q,       col_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    mem_addr_t req_a;
    logic      accept;
    logic      lk_hit;
    logic      lk_open;
    logic      upd_en;

    assign req_a  = split_addr(host.req_addr);
    assign accept = host.req_valid && rdy_q;

    sdram_row_table #(
        .BA_W  (BA_W),
        .ROW_W (ROW_W)
    ) u_row_table (
        .ck        (ck),
        .rst_n     (rst_n),
        .lk_ba_i   (req_a.ba),
        .lk_row_i  (req_a.row),
        .lk_hit_o  (lk_hit),
        .lk_open_o (lk_open),
        .upd_en_i  (upd_en),
        .upd_ba_i  (ba_q),
        .upd_row_i (row_q)
    );

    // Next-state logic: pick the row-miss path on accept, then walk the timed phases.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        ba_d        = ba_q;
        row_d       = row_q;
        col_d       = col_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        upd_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = host.req_we;
                    ba_d    = req_a.ba;
                    row_d   = req_a.row;
                    col_d   = req_a.col;
                    wdata_d = host.req_wdata;
                    if (lk_hit) begin
                        state_d = S_ACCESS;
                    end else if (lk_open) begin
                        state_d = S_PRECHARGE;
                        cnt_d   = CNT_RP;
                    end else begin
                        state_d = S_ACTIVATE;
                        cnt_d   = CNT_RCD;
                    end
                end
            end
            S_PRECHARGE: begin
                if (cnt_q == '0) begin
                    state_d = S_ACTIVATE;
                    cnt_d   = CNT_RCD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACTIVATE: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                    upd_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RDWAIT;
                    cnt_d   = CNT_RD;
                end
            end
            S_RDWAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem.mem_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        rdy_d = (state_d == S_IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            we_q        <= 1'b0;
            ba_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdy_q       <= rdy_d;
            we_q        <= we_d;
            ba_q        <= ba_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign host.req_ready = rdy_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;

    assign mem.mem_en    = (state_q == S_ACCESS);
    assign mem.mem_we_n  = ~((state_q == S_ACCESS) && we_q);
    assign mem.mem_ba    = ba_q;
    assign mem.mem_row   = row_q;
    assign mem.mem_col   = col_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_sdram_ctrl.sv
// Scoreboard bench for sdram_ctrl: directed scenarios plus random traffic.
module tb_sdram_ctrl;
    import sdram_pkg::*;

    localparam int T_RP   = 2;
    localparam int T_RCD  = 2;
    localparam int RD_LAT = 2;
    localparam int AW     = ADDR_W;

    logic ck    = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 ck = ~ck;

    // Cycle stamp: value equals the number of posedges seen so far.
    always @(posedge ck) cyc <= cyc + 1;

    sdram_host_if host_if ();
    sdram_mem_if  mem_if ();

    sdram_ctrl #(
        .BA_W   (BA_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .DATA_W (DATA_W),
        .T_RP   (T_RP),
        .T_RCD  (T_RCD),
        .RD_LAT (RD_LAT)
    ) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .host  (host_if),
        .mem   (mem_if)
    );

    typedef struct {
        int                cyc;
        logic              we;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } rsp_t;

    acc_t accq[$];
    rsp_t rspq[$];

    // Compact storage key: stimulus keeps rows < 8 and columns < 4.
    function automatic logic [7:0] mkey(input logic [BA_W-1:0] ba, input logic [ROW_W-1:0] row,
                                        input logic [COL_W-1:0] col);
        return {ba, row[2:0], col[1:0]};
    endfunction

    function automatic logic [DATA_W-1:0] fill_val(input logic [7:0] k);
        return k ^ 8'hC3;
    endfunction

    // Memory environment: stores what the controller writes, returns data on reads.
    logic [DATA_W-1:0] env_mem [256];
    logic [255:0]      env_wr = '0;

    always @(posedge ck) begin
        if (mem_if.mem_en === 1'b1) begin
            if (mem_if.mem_we_n === 1'b0) begin
                env_mem[mkey(mem_if.mem_ba, mem_if.mem_row, mem_if.mem_col)] <= mem_if.mem_wdata;
                env_wr[mkey(mem_if.mem_ba, mem_if.mem_row, mem_if.mem_col)]  <= 1'b1;
            end else begin
                mem_if.mem_rdata <= env_wr[mkey(mem_if.mem_ba, mem_if.mem_row, mem_if.mem_col)]
                    ? env_mem[mkey(mem_if.mem_ba, mem_if.mem_row, mem_if.mem_col)]
                    : fill_val(mkey(mem_if.mem_ba, mem_if.mem_row, mem_if.mem_col));
            end
        end
    end

    // Reference model: bank state and host-visible memory contents.
    logic              ref_open [8];
    int                ref_row  [8];
    logic [DATA_W-1:0] ref_mem  [256];
    logic              ref_wr   [256];
    logic [DATA_W-1:0] last_rd = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic finish_up();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // Expected behaviour of one accepted request at accept edge e.
    task automatic model_push(input logic we, input logic [BA_W-1:0] ba, input logic [ROW_W-1:0] row,
                              input logic [COL_W-1:0] col, input logic [DATA_W-1:0] wd, input int e);
        int   n;
        acc_t a;
        rsp_t r;
        logic [7:0] k;
        if (ref_open[ba] && ref_row[ba] == int'(row)) n = 0;
        else if (ref_open[ba])                        n = T_RP + T_RCD;
        else                                          n = T_RCD;
        ref_open[ba] = 1'b1;
        ref_row[ba]  = int'(row);
        a.cyc   = e + n;
        a.we    = we;
        a.addr  = {ba, row, col};
        a.wdata = wd;
        accq.push_back(a);
        k = mkey(ba, row, col);
        if (we) begin
            ref_mem[k] = wd;
            ref_wr[k]  = 1'b1;
        end else begin
            r.cyc   = e + n + 1 + RD_LAT;
            r.data  = ref_wr[k] ? ref_mem[k] : fill_val(k);
            last_rd = r.data;
            rspq.push_back(r);
        end
    endtask

    // Monitor: every memory strobe and read response is matched to the scoreboard.
    always @(negedge ck) begin
        acc_t ma;
        rsp_t mr;
        if (mem_if.mem_en === 1'b1) begin
            if (accq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_mem_en: strobe at cycle %0d, none expected", cyc);
            end else begin
                ma = accq.pop_front();
                chk("acc_cycle", 64'(cyc), 64'(ma.cyc));
                chk("acc_addr", 64'({mem_if.mem_ba, mem_if.mem_row, mem_if.mem_col}), 64'(ma.addr));
                chk("acc_we_n", 64'(mem_if.mem_we_n), 64'(!ma.we));
                if (ma.we) chk("acc_wdata", 64'(mem_if.mem_wdata), 64'(ma.wdata));
            end
        end
        if (host_if.rsp_valid === 1'b1) begin
            if (rspq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp_valid: response at cycle %0d, none expected", cyc);
            end else begin
                mr = rspq.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(mr.cyc));
                chk("rsp_data", 64'(host_if.rsp_rdata), 64'(mr.data));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (host_if.req_ready !== 1'b1) begin
            if (n == 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ready_timeout: req_ready=%b after %0d cycles, expected 1", host_if.req_ready, n);
                finish_up();
            end
            @(negedge ck);
            n++;
        end
    endtask

    // Present one request at a negedge and hold it through its accept edge.
    task automatic issue(input logic we, input logic [BA_W-1:0] ba, input logic [ROW_W-1:0] row,
                         input logic [COL_W-1:0] col, input logic [DATA_W-1:0] wd);
        wait_ready();
        host_if.req_valid = 1'b1;
        host_if.req_we    = we;
        host_if.req_addr  = {ba, row, col};
        host_if.req_wdata = wd;
        model_push(we, ba, row, col, wd, cyc + 1);
        @(negedge ck);
        host_if.req_valid = 1'b0;
    endtask

    initial begin
        logic [BA_W-1:0]   rba;
        logic [ROW_W-1:0]  rrow;
        logic [COL_W-1:0]  rcol;
        logic              rwe;
        logic [9:0]        patt;
        int                accepts;
        int                n;

        for (int i = 0; i < 8; i++) begin
            ref_open[i] = 1'b0;
            ref_row[i]  = 0;
        end
        for (int i = 0; i < 256; i++) begin
            ref_wr[i]  = 1'b0;
            ref_mem[i] = '0;
        end
        host_if.req_valid = 1'b0;
        host_if.req_we    = 1'b0;
        host_if.req_addr  = '0;
        host_if.req_wdata = '0;

        // Reset held for three cycles.
        rst_n = 1'b0;
        repeat (3) @(negedge ck);
        chk("rst_ready", 64'(host_if.req_ready), 64'd0);
        chk("rst_mem_en", 64'(mem_if.mem_en), 64'd0);
        chk("rst_mem_we_n", 64'(mem_if.mem_we_n), 64'd1);
        chk("rst_rsp_valid", 64'(host_if.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(host_if.rsp_rdata), 64'd0);
        chk("rst_mem_addr", 64'({mem_if.mem_ba, mem_if.mem_row, mem_if.mem_col}), 64'd0);
        chk("rst_mem_wdata", 64'(mem_if.mem_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge ck);
        chk("ready_after_rst", 64'(host_if.req_ready), 64'd1);

        // Closed-bank write, hit read, two conflicts, independent bank rows.
        issue(1'b1, 3'd0, 15'd5, 10'd3, 8'hA5);
        issue(1'b0, 3'd0, 15'd5, 10'd3, 8'h00);
        issue(1'b1, 3'd0, 15'd6, 10'd3, 8'h3C);
        issue(1'b0, 3'd0, 15'd5, 10'd3, 8'h00);
        issue(1'b1, 3'd1, 15'd5, 10'd0, 8'h11);
        issue(1'b0, 3'd0, 15'd5, 10'd3, 8'h00);
        issue(1'b0, 3'd1, 15'd5, 10'd0, 8'h00);

        // Backpressure: valid held high for ten cycles on hit writes.
        wait_ready();
        patt    = '0;
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            host_if.req_valid = 1'b1;
            host_if.req_we    = 1'b1;
            host_if.req_addr  = {3'd1, 15'd5, 10'd0};
            host_if.req_wdata = 8'($urandom);
            patt = {patt[8:0], host_if.req_ready};
            if (host_if.req_ready === 1'b1) begin
                model_push(1'b1, 3'd1, 15'd5, 10'd0, host_if.req_wdata, cyc + 1);
                accepts++;
            end
            @(negedge ck);
        end
        host_if.req_valid = 1'b0;
        chk("bp_accepts", 64'(accepts), 64'd5);
        chk("bp_ready_pattern", 64'(patt), 64'h2AA);

        // Reset pulse while a read waits for data.
        issue(1'b0, 3'd0, 15'd5, 10'd3, 8'h00);
        @(negedge ck);
        rst_n = 1'b0;
        @(negedge ck);
        chk("midrst_ready", 64'(host_if.req_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(host_if.rsp_valid), 64'd0);
        chk("midrst_mem_en", 64'(mem_if.mem_en), 64'd0);
        chk("midrst_rsp_rdata", 64'(host_if.rsp_rdata), 64'd0);
        rspq.delete();
        accq.delete();
        for (int i = 0; i < 8; i++) ref_open[i] = 1'b0;
        rst_n = 1'b1;
        @(negedge ck);
        chk("midrst_ready_back", 64'(host_if.req_ready), 64'd1);
        issue(1'b0, 3'd0, 15'd5, 10'd3, 8'h00);

        // Random traffic over a small address window to mix hits, misses and conflicts.
        for (int i = 0; i < 40; i++) begin
            rba  = 3'($urandom_range(0, 7));
            rrow = 15'($urandom_range(0, 7));
            rcol = 10'($urandom_range(0, 3));
            rwe  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge ck);
            issue(rwe, rba, rrow, rcol, 8'($urandom));
        end
        issue(1'b0, rba, rrow, rcol, 8'h00);

        // Let the last responses drain, bounded.
        n = 0;
        while ((accq.size() != 0 || rspq.size() != 0) && n < 200) begin
            @(negedge ck);
            n++;
        end
        chk("drain_pending", 64'(accq.size() + rspq.size()), 64'd0);
        repeat (3) @(negedge ck);
        chk("rsp_rdata_held", 64'(host_if.rsp_rdata), 64'(last_rd));
        chk("idle_mem_we_n", 64'(mem_if.mem_we_n), 64'd1);

        finish_up();
    end

endmodule
